// File: rtl/aes_const.sv
// AES round and block constants shared by the cipher core and its schedulers.
package aes_const;

    localparam int Nb = 4;
    localparam int Nk = 4;
    localparam int Nr = 10;

endpackage

// File: rtl/aes_sched_pkg.sv
// Types and constants for the round-robin scheduler in front of the AES round datapath.
package aes_sched_pkg;

    import aes_const::*;

    localparam int AES_LAT  = Nr + 1;
    localparam int ID_MAX_W = 3;
    localparam int CNT_W    = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } sched_state_e;

    typedef logic [0:15][7:0] aes_block_t;

    typedef struct packed {
        aes_block_t            data;
        logic [ID_MAX_W-1:0]   id;
    } rsp_entry_t;

endpackage

// File: rtl/aes_rsp_fifo.sv
// Two-entry response FIFO; push and pop in the same cycle are both honoured.
module aes_rsp_fifo #(
    parameter type entry_t = logic [7:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    output logic       head_valid,
    output entry_t     head_data,
    output logic [1:0] count
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    assign head_valid = (cnt != 2'd0);
    assign head_data  = mem[rd_ptr];
    assign count      = cnt;

endmodule

// File: rtl/aes_cipher_arbiter.sv
// Round-robin scheduler sharing one fixed-latency AES round datapath among NREQ requesters.
// Handshake: a transfer happens in a cycle where valid and ready are both high; ready never waits on valid's reaction.
module aes_cipher_arbiter
    import aes_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [0:NREQ-1][0:15][7:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [0:15][7:0]             rsp_data,
    output logic [IDW-1:0]               rsp_id,
    output logic                         core_enable,
    output logic [0:15][7:0]             core_data_in,
    input  logic [0:15][7:0]             core_data_out,
    input  logic                         core_ready,
    output logic                         err,
    output sched_state_e                 dbg_state
);

    typedef struct packed {
        sched_state_e          state;
        logic [ID_MAX_W-1:0]   cur_id;
        logic [CNT_W-1:0]      cnt;
        logic [ID_MAX_W-1:0]   rr_ptr;
        logic                  err;
    } arb_reg_t;

    localparam arb_reg_t REG_RESET = '{state: IDLE, cur_id: '0, cnt: '0, rr_ptr: '0, err: 1'b0};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(AES_LAT - 1);

    arb_reg_t             r;
    arb_reg_t             rin;
    rsp_entry_t           push_entry;
    rsp_entry_t           head_entry;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [1:0]           fifo_count;
    logic                 done;
    logic                 credit;
    logic                 found;
    logic                 launch;
    logic [ID_MAX_W-1:0]  grant;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r <= REG_RESET;
        end else begin
            r <= rin;
        end
    end

    always_comb begin
        rin          = r;
        req_ready    = '0;
        core_enable  = 1'b0;
        core_data_in = '0;
        fifo_push    = 1'b0;
        push_entry   = '0;
        found        = 1'b0;
        grant        = '0;

        fifo_pop = rsp_valid && rsp_ready;
        done     = (r.state == BUSY) && core_ready;
        // The job finishing this cycle already owns a slot, so count it as occupied.
        credit   = (3'(fifo_count) + 3'(done) - 3'(fifo_pop)) < 3'd2;

        for (int j = 0; j < NREQ; j++) begin
            if (!found && req_valid[j] && (j >= int'(r.rr_ptr))) begin
                found = 1'b1;
                grant = ID_MAX_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req_valid[j]) begin
                found = 1'b1;
                grant = ID_MAX_W'(j);
            end
        end

        launch = rst && ((r.state == IDLE) || done) && found && credit;

        for (int j = 0; j < NREQ; j++) begin
            if (launch && (grant == ID_MAX_W'(j))) begin
                req_ready[j] = 1'b1;
                core_data_in = req_data[j];
            end
        end
        core_enable = launch;

        if (r.state == BUSY) begin
            if (core_ready) begin
                fifo_push       = 1'b1;
                push_entry.data = core_data_out;
                push_entry.id   = r.cur_id;
                if (r.cnt != '0) begin
                    rin.err = 1'b1;
                end
                rin.state = IDLE;
            end else if (r.cnt == '0) begin
                // Core missed its slot: drop the job rather than hang.
                rin.err   = 1'b1;
                rin.state = IDLE;
            end else begin
                rin.cnt = r.cnt - 1'b1;
            end
        end else if (core_ready) begin
            rin.err = 1'b1;
        end

        if (launch) begin
            rin.state  = BUSY;
            rin.cur_id = grant;
            rin.cnt    = CNT_LOAD;
            rin.rr_ptr = (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
        end
    end

    aes_rsp_fifo #(
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (push_entry),
        .pop        (fifo_pop),
        .head_valid (rsp_valid),
        .head_data  (head_entry),
        .count      (fifo_count)
    );

    assign rsp_data  = head_entry.data;
    assign rsp_id    = IDW'(head_entry.id);
    assign err       = r.err;
    assign dbg_state = r.state;

endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// Bench for aes_cipher_arbiter with a mock fixed-latency core and a response scoreboard.
`timescale 1ns/1ps

module tb_aes_cipher_arbiter;
  import aes_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int NR   = 10;
  localparam int W    = 128 + IDW;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [NREQ-1:0]             req_valid = '0;
  logic [0:NREQ-1][0:15][7:0]  req_data = '0;
  logic [NREQ-1:0]             req_ready;
  logic                        rsp_valid;
  logic                        rsp_ready = 1'b1;
  logic [0:15][7:0]            rsp_data;
  logic [IDW-1:0]              rsp_id;
  logic                        core_enable;
  logic [0:15][7:0]            core_data_in;
  logic [0:15][7:0]            core_data_out = '0;
  logic                        core_ready = 1'b0;
  logic                        err;
  sched_state_e                dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_rr = 0;
  int core_mode = 0;
  logic force_rdy = 1'b0;
  int ready_at = -1;
  logic [127:0] pend = '0;

  logic [W-1:0] exp_q[$];
  int grant_log[$];
  int launch_cyc[$];

  aes_cipher_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .core_enable   (core_enable),
    .core_data_in  (core_data_in),
    .core_data_out (core_data_out),
    .core_ready    (core_ready),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stand-in for the keyed cipher: the FIPS-197 vector maps to its known ciphertext.
  function automatic logic [127:0] mock(input logic [127:0] d);
    if (d == PT) return CT;
    return {d[63:0], d[127:64]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_1234_8765;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  // Mock core: mode 0 normal latency, 1 one cycle early, 2 never answers.
  always @(negedge clk) begin
    if (!rst) begin
      ready_at = -1;
    end else if (core_enable) begin
      pend     = mock(core_data_in);
      ready_at = (core_mode == 2) ? -1 : cyc + ((core_mode == 1) ? NR : NR + 1);
    end
  end

  always @(posedge clk) begin
    #2;
    core_ready    = force_rdy || (cyc == ready_at);
    core_data_out = (cyc == ready_at) ? pend : '0;
  end

  always @(negedge clk) begin
    int g;
    logic [W-1:0] e;
    if (!rst) begin
      model_rr = 0;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $error("FAIL ready_in_reset: observed %0h expected %0h", req_ready, 4'b0000);
      end
      checks++;
      if (core_enable !== 1'b0) begin
        errors++;
        $error("FAIL enable_in_reset: observed %0h expected %0h", core_enable, 1'b0);
      end
    end else begin
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          if ({rsp_data, rsp_id} !== e) begin
            errors++;
            $error("FAIL rsp_entry: observed %0h expected %0h", {rsp_data, rsp_id}, e);
          end
        end
      end
      checks++;
      if (core_enable !== (|req_ready)) begin
        errors++;
        $error("FAIL enable_vs_ready: observed %0h expected %0h", core_enable, |req_ready);
      end
      checks++;
      if ($onehot0(req_ready) !== 1'b1) begin
        errors++;
        $error("FAIL ready_onehot0: observed %0h expected %0h", req_ready, 1'b1);
      end
      if (!core_enable) begin
        checks++;
        if (core_data_in !== 128'h0) begin
          errors++;
          $error("FAIL data_in_idle_zero: observed %0h expected %0h", core_data_in, 128'h0);
        end
      end
      if (|req_ready) begin
        g = model_grant(req_valid, model_rr);
        checks++;
        if (req_ready !== 4'(1 << g)) begin
          errors++;
          $error("FAIL grant: observed %0h expected %0h", req_ready, 4'(1 << g));
        end
        checks++;
        if (core_data_in !== req_data[g]) begin
          errors++;
          $error("FAIL data_in: observed %0h expected %0h", core_data_in, req_data[g]);
        end
        check("credit", exp_q.size() <= 1, 1'b1);
        exp_q.push_back({mock(req_data[g]), IDW'(g)});
        model_rr = (g + 1) % NREQ;
        grant_log.push_back(g);
        launch_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget, input string tag, output int gcyc);
    gcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (|req_ready) begin
        gcyc = cyc;
        break;
      end
    end
    check({tag, "_grant_seen"}, gcyc >= 0, 1'b1);
  endtask

  task automatic drain(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_drained"}, ok, 1'b1);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NREQ; i++) begin
      req_data[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    int t;
    int t2;
    int lat;
    bit seen;
    logic [127:0] d_a;
    logic [127:0] d_b;

    repeat (3) tick();
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 128'h0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, IDLE);

    // All requesters continuously valid.
    randomize_data();
    grant_log.delete();
    launch_cyc.delete();
    tick();
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 200 && grant_log.size() < 8; i++) @(negedge clk);
    check("rr_eight_grants", grant_log.size() >= 8, 1'b1);
    tick();
    req_valid = '0;
    if (grant_log.size() >= 8) begin
      for (int i = 0; i < 8; i++) check("rr_order", grant_log[i], i % NREQ);
      for (int i = 1; i < 8; i++) check("rr_interval", launch_cyc[i] - launch_cyc[i-1], NR + 1);
    end
    drain(60, "rr");

    // Single FIPS-197 request on requester 2.
    req_data[2] = PT;
    tick();
    req_valid = 4'b0100;
    wait_grant(5, "fips", t);
    check("fips_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - t;
        break;
      end
    end
    check("fips_latency", lat, NR + 2);
    check("fips_data", rsp_data, CT);
    check("fips_id", rsp_id, 2'd2);
    drain(20, "fips");

    // Backpressure: two results fill the FIFO, then launching stops.
    randomize_data();
    rsp_ready = 1'b0;
    grant_log.delete();
    tick();
    req_valid = '1;
    repeat (60) @(negedge clk);
    check("bp_two_launches", grant_log.size(), 2);
    check("bp_no_ready", req_ready, 4'b0000);
    check("bp_rsp_valid", rsp_valid, 1'b1);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_launch", |req_ready, 1'b1);
    tick();
    req_valid = '0;
    drain(60, "bp");

    // Simultaneous push and pop with one entry held.
    rsp_ready = 1'b0;
    d_a = {$urandom, $urandom, $urandom, $urandom};
    d_b = {$urandom, $urandom, $urandom, $urandom};
    req_data[1] = d_a;
    tick();
    req_valid = 4'b0010;
    wait_grant(5, "pp_a", t);
    tick();
    req_data[1] = d_b;
    wait_grant(20, "pp_b", t2);
    check("pp_b2b", t2 - t, NR + 1);
    tick();
    req_valid = '0;
    repeat (10) tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pp_core_ready", core_ready, 1'b1);
    check("pp_head_a_valid", rsp_valid, 1'b1);
    check("pp_head_a", rsp_data, mock(d_a));
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("pp_occ_one", rsp_valid, 1'b1);
    check("pp_head_b", rsp_data, mock(d_b));
    check("pp_head_b_id", rsp_id, 2'd1);
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("pp_empty", rsp_valid, 1'b0);

    // Reset in the middle of a job.
    randomize_data();
    tick();
    req_valid = 4'b0100;
    wait_grant(5, "rstjob", t);
    tick();
    req_valid = '0;
    repeat (4) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstjob_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rstjob_rsp_valid", rsp_valid, 1'b0);
    check("rstjob_rsp_data", rsp_data, 128'h0);
    check("rstjob_state", dbg_state, IDLE);
    check("rstjob_err", err, 1'b0);
    exp_q.delete();
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rstjob_no_rsp", seen, 1'b0);
    tick();
    req_valid = '1;
    wait_grant(5, "rstjob_rr", t);
    check("rstjob_rr_zero", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain(40, "rstjob");

    // Core answers one cycle early: error, result still delivered.
    check("early_err_before", err, 1'b0);
    core_mode = 1;
    tick();
    req_valid = 4'b1000;
    wait_grant(5, "early", t);
    tick();
    req_valid = '0;
    drain(40, "early");
    check("early_err", err, 1'b1);
    repeat (5) tick();
    check("early_err_sticky", err, 1'b1);
    core_mode = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("err_cleared", err, 1'b0);

    // core_ready while idle.
    tick();
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    @(negedge clk);
    check("idle_ready_err", err, 1'b1);
    check("idle_ready_state", dbg_state, IDLE);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("err_cleared2", err, 1'b0);

    // Core never answers: job dropped after the latency window.
    core_mode = 2;
    tick();
    req_valid = 4'b0001;
    wait_grant(5, "never", t);
    tick();
    req_valid = '0;
    repeat (9) tick();
    @(negedge clk);
    check("never_busy_t10", dbg_state, BUSY);
    tick();
    @(negedge clk);
    check("never_busy_t11", dbg_state, BUSY);
    check("never_err_t11", err, 1'b0);
    tick();
    @(negedge clk);
    check("never_idle_t12", dbg_state, IDLE);
    check("never_err_t12", err, 1'b1);
    exp_q.delete();
    core_mode = 0;
    repeat (5) tick();
    check("never_no_rsp", rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_cipher_arbiter.md
# aes_cipher_arbiter

Round-robin scheduler that shares one `aes_cipher_state` round datapath among `NREQ` requesters. It accepts a 16-byte block from one requester at a time and pulses the core's `Enable`. It waits the fixed Nr+1-cycle latency, captures the one-cycle-valid result, and returns it with the requester's ID through a 2-entry response FIFO with backpressure. It sits between the key-expanded cipher core and the block-level request fabric.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: response ID width.
- `clk`  in  1: the single clock. All logic is rising-edge.
- `rst`  in  1: reset, synchronous and active-low (0 = reset).
- `req_valid`  in  `[NREQ-1:0]`: per-requester block valid.
- `req_data`  in  `[7:0] [0:NREQ-1][0:15]`: per-requester plaintext bytes.
- `req_ready`  out  `[NREQ-1:0]`: one-hot accept. At most one bit is high per cycle.
- `rsp_valid`  out  1: response FIFO head valid.
- `rsp_ready`  in  1: consumer accepts the head.
- `rsp_data`  out  `[7:0] [0:15]`: ciphertext.
- `rsp_id`  out  `IDW`: index of the originating requester.
- `core_enable`  out  1: drives the core's `Enable`.
- `core_data_in`  out  `[7:0] [0:15]`: drives the core's `Data_in`.
- `core_data_out`  in  `[7:0] [0:15]`: from the core's `Data_out`.
- `core_ready`  in  1: from the core's `Ready_out`.
- `err`  out  1: sticky latency-violation flag.

## Operation
- FSM states:
  - IDLE: no job in flight.
  - BUSY: job in flight. Holds `cur_id` and down-counter `cnt`.
- Launch condition: (IDLE, or BUSY with `core_ready`=1) and `|req_valid` and `credit`.
  - `credit` = FIFO free entries after this cycle's pop ≥ 1, counting the job completing this cycle.
- On launch:
  - Grant `g` is the first valid requester at or after `rr_ptr`, in wrap-around order.
  - `req_ready[g]`=1 and `core_enable`=1, same cycle, combinationally.
  - `core_data_in` = `req_data[g]`.
  - Next state: `cur_id`←`g`, `rr_ptr`←(`g`+1) mod `NREQ`, `cnt`←Nr, state←BUSY.
- When not launching: `core_enable`=0 and `core_data_in` is all zero.
- BUSY, each cycle without `core_ready`:
  - `cnt` decrements.
  - If `cnt`=0 and no `core_ready`: set `err`, return to IDLE, drop the job.
- `core_ready`=1 while BUSY:
  - If `cnt`≠0: set `err` and capture the result anyway.
  - Push {`core_data_out`, `cur_id`} into the FIFO. `core_data_out` is valid only in this cycle.
  - With no new launch: state←IDLE.
- `core_ready` while IDLE: ignored, and `err` is set.
- FIFO:
  - 2 entries, head on `rsp_*`.
  - Push and pop in the same cycle are both honoured.
  - Full is never pushed, guaranteed by `credit`.
  - Pop when `rsp_valid` and `rsp_ready`.
- `err` is cleared only by reset.

## Timing
- Launch at cycle t: core `Ready_out` at t+Nr+1, FIFO push at the same edge, `rsp_valid` at t+Nr+2.
- Back-to-back: a new launch is allowed in the `core_ready` cycle, so throughput is one block per Nr+1 cycles.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Reset values (`rst`=0 at an edge):
  - State IDLE, `rr_ptr`=0, `cnt`=0, FIFO empty.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `err`=0.
  - `req_ready`=0 and `core_enable`=0 while `rst`=0.
- Reset mid-job: the job is discarded. The core shares `rst`, so no stale `core_ready` is expected.
- Requester holding `req_valid` without grant: it must keep its data stable until granted.

## Structure
- `Nr`, `Nb` come from `aes_const`.
- New package `aes_sched_pkg` holds:
  - FSM enum `{IDLE, BUSY}`.
  - FIFO entry struct `{data[0:15], id}`.
  - `AES_LAT = Nr+1`.
- The arbiter uses the `r`/`rin` two-process register style.
- One sub-module: `aes_rsp_fifo`, a 2-entry FIFO parameterised by entry type, with synchronous active-low reset.
- Top-level integration wires this block to `aes_cipher_state`. The key schedule is outside scope.

## Test plan
- Single request: `req_valid[2]`=1, FIPS-197 plaintext 00112233…ff, AES-128 key 000102…0f. Required: `req_ready[2]` in the same cycle, `rsp_data` = 69c4e0d8…c55a, `rsp_id`=2, `rsp_valid` rises exactly Nr+2 cycles after launch.
- All four requesters valid continuously, `rsp_ready`=1. Required: grant order 0,1,2,3,0…, one launch every Nr+1 cycles, IDs returned in grant order.
- `rsp_ready`=0 with requests pending. Required: two results accepted into the FIFO, then no launch; `req_ready` stays 0. Raising `rsp_ready` resumes launching in the first cycle a slot frees.
- Reset asserted at cycle 5 of a job. Required: outputs go to their reset values at the next edge, no response emitted, `rr_ptr` back to 0.
- Core model that raises `core_ready` one cycle early. Required: `err`=1 (sticky), result still pushed. A core model that never raises `core_ready`: `err`=1 and the FSM returns to IDLE after Nr+1 cycles.
- Simultaneous FIFO push and pop with 1 entry. Required: occupancy stays 1 and the data order is preserved.
